// File: rtl/dkong_snd_post.sv
// -----------------------------------------------------------------------------
// dkong_snd_post
//   Audio post-processing for the dkong_top sound stream. The 8-bit unsigned
//   input is boxcar-averaged over 2^DIV_LOG2 clocks, run through a first-order
//   IIR low-pass and a DC-blocking high-pass, and emitted as a saturated signed
//   16-bit PCM sample with a one-cycle valid strobe.
//
// Ports
//   I_CLK_24576M  in   1  system clock, rising edge
//   I_RST         in   1  synchronous active-high reset
//   I_SND_DAT     in   8  unsigned sound sample, taken every clock
//   I_MUTE        in   1  forces the emitted sample to 0; filters keep running
//   O_SAMPLE      out 16  signed PCM sample, held between strobes
//   O_VALID       out  1  high for exactly the cycle O_SAMPLE was refreshed
// -----------------------------------------------------------------------------
module dkong_snd_post #(
  parameter int unsigned DIV_LOG2  = 9,
  parameter int unsigned LPF_SHIFT = 2,
  parameter int unsigned HPF_SHIFT = 8
) (
  input  logic        I_CLK_24576M,
  input  logic        I_RST,
  input  logic [7:0]  I_SND_DAT,
  input  logic        I_MUTE,
  output logic [15:0] O_SAMPLE,
  output logic        O_VALID
);

  localparam int unsigned ACC_W = 8 + DIV_LOG2;
  localparam int unsigned DSP_W = 18;

  localparam logic signed [DSP_W-1:0] SAT_MAX = 18'sd32767;
  localparam logic signed [DSP_W-1:0] SAT_MIN = -18'sd32768;

  typedef enum logic [1:0] {
    S_ACC,
    S_LPF,
    S_HPF,
    S_OUT
  } state_e;

  // Decimator state
  logic [DIV_LOG2-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    acc_sum_c;
  logic [7:0]          avg_q, avg_d;
  logic                wrap_c;

  // Filter / output state
  state_e                  state_q, state_d;
  logic signed [DSP_W-1:0] lp_q, lp_d;
  logic signed [DSP_W-1:0] dc_q, dc_d;
  logic [15:0]             sample_q, sample_d;
  logic                    valid_q, valid_d;

  // Filter datapath
  logic signed [DSP_W-1:0] x_c;
  logic signed [DSP_W-1:0] lp_new_c;
  logic signed [DSP_W-1:0] dc_new_c;
  logic signed [DSP_W-1:0] hp_c;

  // Clamp an 18-bit signed value into the 16-bit PCM range.
  function automatic logic [15:0] sat16(input logic signed [DSP_W-1:0] v);
    logic [15:0] r;
    if (v > SAT_MAX) begin
      r = 16'h7FFF;
    end else if (v < SAT_MIN) begin
      r = 16'h8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  // Boxcar decimator: the wrap cycle folds in its own input sample, so the
  // average always covers exactly 2^DIV_LOG2 samples and acc restarts clean.
  always_comb begin
    wrap_c    = &cnt_q;
    acc_sum_c = acc_q + ACC_W'(I_SND_DAT);
    cnt_d     = cnt_q + DIV_LOG2'(1);
    acc_d     = wrap_c ? '0 : acc_sum_c;
    avg_d     = wrap_c ? acc_sum_c[ACC_W-1 -: 8] : avg_q;
  end

  // IIR arithmetic. dc_new_c is evaluated in S_HPF, where lp_q already holds
  // the value written in S_LPF.
  always_comb begin
    x_c      = $signed({2'b00, avg_q, 8'h00});
    lp_new_c = lp_q + ((x_c - lp_q) >>> LPF_SHIFT);
    dc_new_c = dc_q + ((lp_q - dc_q) >>> HPF_SHIFT);
    hp_c     = lp_q - dc_new_c;
  end

  // Sequencer. The output registers are loaded on the edge that enters S_OUT,
  // so O_VALID is high exactly while the FSM sits in S_OUT.
  always_comb begin
    state_d  = state_q;
    lp_d     = lp_q;
    dc_d     = dc_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    unique case (state_q)
      S_ACC: begin
        if (wrap_c) begin
          state_d = S_LPF;
        end
      end
      S_LPF: begin
        lp_d    = lp_new_c;
        state_d = S_HPF;
      end
      S_HPF: begin
        dc_d     = dc_new_c;
        sample_d = I_MUTE ? 16'h0000 : sat16(hp_c);
        valid_d  = 1'b1;
        state_d  = S_OUT;
      end
      S_OUT: begin
        state_d = S_ACC;
      end
      default: begin
        state_d = S_ACC;
      end
    endcase
  end

  // State registers
  always_ff @(posedge I_CLK_24576M) begin
    if (I_RST) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      avg_q    <= '0;
      state_q  <= S_ACC;
      lp_q     <= '0;
      dc_q     <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      avg_q    <= avg_d;
      state_q  <= state_d;
      lp_q     <= lp_d;
      dc_q     <= dc_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign O_SAMPLE = sample_q;
  assign O_VALID  = valid_q;

endmodule
